// File: rtl/alu_issue.sv
// ============================================================================
// Module      : alu_issue
// Description : Decode/issue stage for the 16-bit ALU. A scoreboard blocks
//               RAW/WAW hazards, and a one-entry valid/ready output register
//               holds the {opcode, A, B, rd} bundle sent to EX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue #(
    parameter int NREG = 16,
    parameter int DW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [15:0]   in_instr,
    output logic          in_ready,
    output logic [3:0]    rf_raddr1,
    output logic [3:0]    rf_raddr2,
    input  logic [DW-1:0] rf_rdata1,
    input  logic [DW-1:0] rf_rdata2,
    output logic          ex_valid,
    input  logic          ex_ready,
    output logic [2:0]    ex_opcode,
    output logic [DW-1:0] ex_A,
    output logic [DW-1:0] ex_B,
    output logic [3:0]    ex_rd,
    input  logic          wb_valid,
    input  logic [3:0]    wb_rd,
    output logic          illegal
);

    logic [3:0]      w_op;
    logic [3:0]      w_rd;
    logic [3:0]      w_rs;
    logic [3:0]      w_rt;
    logic            w_uses_rt;
    logic [NREG-1:0] w_wb_mask;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_pend_eff;
    logic            w_hazard;
    logic            w_slot_free;
    logic            w_issue;
    logic            w_drop;
    logic [DW-1:0]   w_opa;
    logic [DW-1:0]   w_opb;

    logic [NREG-1:0] r_pending;
    logic            r_ex_valid;
    logic [2:0]      r_ex_opcode;
    logic [DW-1:0]   r_ex_A;
    logic [DW-1:0]   r_ex_B;
    logic [3:0]      r_ex_rd;
    logic            r_illegal;

    assign w_op      = in_instr[15:12];
    assign w_rd      = in_instr[11:8];
    assign w_rs      = in_instr[7:4];
    assign w_rt      = in_instr[3:0];
    assign rf_raddr1 = w_rs;
    assign rf_raddr2 = w_rt;

    // Shift/rotate ops carry a 4-bit immediate in the rt field.
    assign w_uses_rt = !(w_op[2:0] == 3'd4 || w_op[2:0] == 3'd5 || w_op[2:0] == 3'd6);

    always_comb begin
        w_wb_mask = '0;
        if (wb_valid && wb_rd != 4'd0) w_wb_mask[wb_rd] = 1'b1;
    end

    // Writeback in the same cycle releases the hazard immediately.
    assign w_pend_eff  = r_pending & ~w_wb_mask;
    assign w_hazard    = w_pend_eff[w_rs] | (w_uses_rt & w_pend_eff[w_rt]) | w_pend_eff[w_rd];
    assign w_slot_free = ~r_ex_valid | ex_ready;
    assign in_ready    = w_op[3] ? 1'b1 : (w_slot_free & ~w_hazard);
    assign w_issue     = in_valid & in_ready & ~w_op[3];
    assign w_drop      = in_valid & w_op[3];

    always_comb begin
        w_set_mask = '0;
        if (w_issue && w_rd != 4'd0) w_set_mask[w_rd] = 1'b1;
    end

    assign w_opa = (w_rs == 4'd0) ? '0 : rf_rdata1;
    assign w_opb = !w_uses_rt      ? {{(DW-4){1'b0}}, w_rt} :
                   (w_rt == 4'd0)  ? '0 : rf_rdata2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_ex_valid  <= 1'b0;
            r_ex_opcode <= 3'd0;
            r_ex_A      <= '0;
            r_ex_B      <= '0;
            r_ex_rd     <= 4'd0;
            r_illegal   <= 1'b0;
        end else begin
            r_pending <= w_pend_eff | w_set_mask;
            r_illegal <= w_drop;
            if (w_issue) begin
                r_ex_valid  <= 1'b1;
                r_ex_opcode <= w_op[2:0];
                r_ex_A      <= w_opa;
                r_ex_B      <= w_opb;
                r_ex_rd     <= w_rd;
            end else if (ex_ready) begin
                r_ex_valid  <= 1'b0;
            end
        end
    end

    assign ex_valid  = r_ex_valid;
    assign ex_opcode = r_ex_opcode;
    assign ex_A      = r_ex_A;
    assign ex_B      = r_ex_B;
    assign ex_rd     = r_ex_rd;
    assign illegal   = r_illegal;

endmodule

`default_nettype wire
